// File: rtl/clk_reconfig_pkg.sv
// Shared definitions for the clock-wizard DRP reconfiguration controller.
//   state_t     - controller states
//   drp_entry_t - one DRP read-modify-write step {addr, mask, data};
//                 a mask bit of 1 keeps the bit read back from the wizard
//   CFG_TABLE   - two configurations of CFG_DEPTH register writes each
//   cfg_entry() - table lookup that returns an all-zero entry when out of range
package clk_reconfig_pkg;

    typedef enum logic [3:0] {
        LOCK_WAIT,
        IDLE,
        ASSERT_RST,
        RD,
        RD_WAIT,
        WR,
        WR_WAIT,
        RELEASE,
        ERR
    } state_t;

    typedef struct packed {
        logic [6:0]  addr;
        logic [15:0] mask;
        logic [15:0] data;
    } drp_entry_t;

    localparam int CFG_DEPTH = 4;
    localparam int CFG_IDX_W = 2;

    // Packed so it can be indexed as CFG_TABLE[cfg][idx]; the concatenation
    // lists configuration 1 first, each row from entry 3 down to entry 0.
    localparam drp_entry_t [1:0][CFG_DEPTH-1:0] CFG_TABLE = {
        {7'h15, 16'hFC00, 16'h00C0}, {7'h14, 16'h1000, 16'h0186},
        {7'h09, 16'hFC00, 16'h0080}, {7'h08, 16'h1000, 16'h0145},
        {7'h15, 16'hFC00, 16'h0000}, {7'h14, 16'h1000, 16'h0104},
        {7'h09, 16'hFC00, 16'h0040}, {7'h08, 16'h1000, 16'h0082}
    };

    function automatic drp_entry_t cfg_entry(input logic cfg, input logic [7:0] idx);
        drp_entry_t e;
        e = '0;
        if (idx < 8'(CFG_DEPTH)) begin
            e = CFG_TABLE[cfg][idx[CFG_IDX_W-1:0]];
        end
        return e;
    endfunction

endpackage

// File: rtl/clk_reconfig_sync2.sv
// Two-flop synchronizer for the asynchronous clock-wizard lock signal.
//   clk_i   - destination clock
//   rst_n_i - asynchronous active-low reset, clears both flops
//   d_i     - asynchronous input
//   q_o     - synchronized output
module clk_reconfig_sync2 (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/clk_reconfig_ctrl.sv
// Reconfigures a clock wizard over DRP: holds it in reset, performs N_REGS
// read-modify-write accesses from the selected table row, releases reset and
// waits for relock. All outputs are registered from the next state.
//   sys_clk, sys_rst_n       - system/DRP clock, async active-low reset
//   cfg_req, cfg_sel         - load request and configuration index
//   busy, done, err          - status (done is a one-cycle pulse after relock)
//   mmcm_rst, locked         - wizard reset and (asynchronous) lock
//   drp_*                    - DRP port
//   rst_n_out                - downstream reset, released only while idle and locked
module clk_reconfig_ctrl
    import clk_reconfig_pkg::*;
#(
    parameter int N_REGS       = 4,
    parameter int DRP_TIMEOUT  = 64,
    parameter int LOCK_TIMEOUT = 50000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        cfg_req,
    input  logic        cfg_sel,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        mmcm_rst,
    input  logic        locked,
    output logic [6:0]  drp_daddr,
    output logic [15:0] drp_di,
    output logic        drp_den,
    output logic        drp_dwe,
    input  logic [15:0] drp_do,
    input  logic        drp_drdy,
    output logic        rst_n_out
);

    localparam int IDX_W   = (N_REGS > 1) ? $clog2(N_REGS) : 1;
    localparam int TMR_MAX = (DRP_TIMEOUT > LOCK_TIMEOUT) ? DRP_TIMEOUT : LOCK_TIMEOUT;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REGS - 1);
    localparam logic [TMR_W-1:0] DRP_LAST  = TMR_W'(DRP_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] LOCK_LAST = TMR_W'(LOCK_TIMEOUT - 1);

    logic locked_s;

    clk_reconfig_sync2 u_lock_sync (
        .clk_i   (sys_clk),
        .rst_n_i (sys_rst_n),
        .d_i     (locked),
        .q_o     (locked_s)
    );

    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic             cfg_q, cfg_d;
    logic [15:0]      rdata_q, rdata_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             mmcm_rst_q, mmcm_rst_d;
    logic [6:0]       daddr_q, daddr_d;
    logic [15:0]      di_q, di_d;
    logic             den_q, den_d;
    logic             dwe_q, dwe_d;
    logic             rst_n_out_q, rst_n_out_d;
    drp_entry_t       entry;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        cfg_d   = cfg_q;
        rdata_d = rdata_q;
        case (state_q)
            LOCK_WAIT: begin
                if (locked_s) begin
                    state_d = IDLE;
                end else if (timer_q == LOCK_LAST) begin
                    state_d = ERR;
                end
            end
            // A request beats a simultaneous loss of lock.
            IDLE, ERR: begin
                if (cfg_req) begin
                    cfg_d   = cfg_sel;
                    index_d = '0;
                    state_d = ASSERT_RST;
                end else if (state_q == IDLE && !locked_s) begin
                    state_d = LOCK_WAIT;
                end
            end
            ASSERT_RST: state_d = RD;
            RD:         state_d = RD_WAIT;
            RD_WAIT: begin
                if (drp_drdy) begin
                    rdata_d = drp_do;
                    state_d = WR;
                end else if (timer_q == DRP_LAST) begin
                    state_d = ERR;
                end
            end
            WR:         state_d = WR_WAIT;
            WR_WAIT: begin
                if (drp_drdy) begin
                    if (index_q == LAST_IDX) begin
                        state_d = RELEASE;
                    end else begin
                        index_d = index_q + 1'b1;
                        state_d = RD;
                    end
                end else if (timer_q == DRP_LAST) begin
                    state_d = ERR;
                end
            end
            RELEASE:    state_d = LOCK_WAIT;
            default:    state_d = LOCK_WAIT;
        endcase

        // Timer restarts on every state entry and only runs in the wait states.
        timer_d = '0;
        if (state_d == state_q &&
            (state_q == LOCK_WAIT || state_q == RD_WAIT || state_q == WR_WAIT)) begin
            timer_d = timer_q + 1'b1;
        end
    end

    // Output decode from the next state so outputs line up with state_q.
    always_comb begin
        entry       = cfg_entry(cfg_d, 8'(index_d));
        daddr_d     = daddr_q;
        di_d        = di_q;
        den_d       = (state_d == RD) || (state_d == WR);
        dwe_d       = (state_d == WR);
        err_d       = (state_d == ERR);
        rst_n_out_d = (state_q == IDLE) && locked_s;
        // done only on the relock that closes a reconfiguration
        done_d      = (state_q == LOCK_WAIT) && (state_d == IDLE) && busy_q;

        case (state_d)
            ASSERT_RST, RD, RD_WAIT, WR, WR_WAIT, ERR: mmcm_rst_d = 1'b1;
            default:                                   mmcm_rst_d = 1'b0;
        endcase

        // LOCK_WAIT inherits busy: set after RELEASE, clear after power-up or lock loss.
        case (state_d)
            ASSERT_RST, RD, RD_WAIT, WR, WR_WAIT, RELEASE: busy_d = 1'b1;
            LOCK_WAIT:                                     busy_d = busy_q;
            default:                                       busy_d = 1'b0;
        endcase

        if (state_d == RD) begin
            daddr_d = entry.addr;
        end
        if (state_d == WR) begin
            daddr_d = entry.addr;
            di_d    = (rdata_d & entry.mask) | entry.data;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= LOCK_WAIT;
            timer_q     <= '0;
            index_q     <= '0;
            cfg_q       <= 1'b0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mmcm_rst_q  <= 1'b1;
            daddr_q     <= '0;
            di_q        <= '0;
            den_q       <= 1'b0;
            dwe_q       <= 1'b0;
            rst_n_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            index_q     <= index_d;
            cfg_q       <= cfg_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            mmcm_rst_q  <= mmcm_rst_d;
            daddr_q     <= daddr_d;
            di_q        <= di_d;
            den_q       <= den_d;
            dwe_q       <= dwe_d;
            rst_n_out_q <= rst_n_out_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign mmcm_rst  = mmcm_rst_q;
    assign drp_daddr = daddr_q;
    assign drp_di    = di_q;
    assign drp_den   = den_q;
    assign drp_dwe   = dwe_q;
    assign rst_n_out = rst_n_out_q;

endmodule

// File: tb/tb_clk_reconfig_ctrl.sv
// Directed bench for clk_reconfig_ctrl with a DRP responder (drdy three
// cycles after den) and a clock-wizard lock model.
module tb_clk_reconfig_ctrl;

    localparam int LOCK_TO = 300;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        cfg_req = 1'b0;
    logic        cfg_sel = 1'b0;
    logic        busy, done, err, mmcm_rst;
    logic        locked;
    logic [6:0]  drp_daddr;
    logic [15:0] drp_di;
    logic        drp_den, drp_dwe;
    logic [15:0] drp_do = 16'h0;
    logic        drp_drdy = 1'b0;
    logic        rst_n_out;

    // lock model controls (written by the stimulus process only)
    logic        lock_mode = 1'b0;     // 0: lock_manual drives locked, 1: auto model
    logic        lock_manual = 1'b0;
    logic        lock_block = 1'b0;    // auto model never relocks
    logic        auto_locked = 1'b0;
    int          lock_cnt = 0;
    logic [15:0] rd_value = 16'hFFFF;
    int          withhold_at = -1;     // 1-based read number left unanswered

    // responder state / logs (written by the model process only)
    int          rsp_cnt = 0;
    int          done_cnt = 0;
    int          rst_viol = 0;
    int          den_cyc = 0;
    int          cyc = 0;
    logic [6:0]  rd_addr_q[$];
    logic [6:0]  wr_addr_q[$];
    logic [15:0] wr_di_q[$];

    int checks = 0;
    int failures = 0;

    assign locked = lock_mode ? auto_locked : lock_manual;

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    clk_reconfig_ctrl #(
        .N_REGS       (4),
        .DRP_TIMEOUT  (64),
        .LOCK_TIMEOUT (LOCK_TO)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .cfg_req   (cfg_req),
        .cfg_sel   (cfg_sel),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mmcm_rst  (mmcm_rst),
        .locked    (locked),
        .drp_daddr (drp_daddr),
        .drp_di    (drp_di),
        .drp_den   (drp_den),
        .drp_dwe   (drp_dwe),
        .drp_do    (drp_do),
        .drp_drdy  (drp_drdy),
        .rst_n_out (rst_n_out)
    );

    // DRP responder, done counter and wizard lock model
    always @(negedge sys_clk) begin
        drp_drdy = 1'b0;
        drp_do   = rd_value;
        if (rsp_cnt > 0) begin
            rsp_cnt = rsp_cnt - 1;
            if (rsp_cnt == 0) drp_drdy = 1'b1;
        end
        if (drp_den) begin
            den_cyc = cyc;
            if (!mmcm_rst) rst_viol = rst_viol + 1;
            if (drp_dwe) begin
                wr_addr_q.push_back(drp_daddr);
                wr_di_q.push_back(drp_di);
                rsp_cnt = 3;
            end else begin
                rd_addr_q.push_back(drp_daddr);
                if (rd_addr_q.size() != withhold_at) rsp_cnt = 3;
            end
        end
        if (done) done_cnt = done_cnt + 1;
        if (mmcm_rst) begin
            auto_locked = 1'b0;
            lock_cnt    = 0;
        end else if (!auto_locked && !lock_block) begin
            lock_cnt = lock_cnt + 1;
            if (lock_cnt >= 10) auto_locked = 1'b1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    function automatic bit cond(input int sel);
        case (sel)
            0:       return rst_n_out == 1'b1;
            1:       return busy == 1'b0;
            2:       return err == 1'b1;
            3:       return mmcm_rst == 1'b0;
            default: return drp_den == 1'b1;
        endcase
    endfunction

    // Wait at negedges until cond(sel) holds; an expired budget is a failure.
    task automatic wait_cond(input int sel, input int budget, input string tag);
        int n;
        n = 0;
        while (!cond(sel) && n < budget) begin
            @(negedge sys_clk);
            n = n + 1;
        end
        check_eq(tag, 32'(cond(sel)), 32'd1);
    endtask

    task automatic request(input logic sel);
        cfg_sel = sel;
        cfg_req = 1'b1;
        @(negedge sys_clk);
        cfg_req = 1'b0;
    endtask

    // Four RMW accesses to 08,09,14,15 with the given write data.
    task automatic check_run(input string tag, input int rbase, input int wbase,
                             input logic [15:0] d0, input logic [15:0] d1,
                             input logic [15:0] d2, input logic [15:0] d3);
        logic [6:0]  ea[4];
        logic [15:0] ed[4];
        ea = '{7'h08, 7'h09, 7'h14, 7'h15};
        ed = '{d0, d1, d2, d3};
        check_eq({tag, "_nrd"}, 32'(rd_addr_q.size() - rbase), 32'd4);
        check_eq({tag, "_nwr"}, 32'(wr_addr_q.size() - wbase), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (rbase + i < rd_addr_q.size())
                check_eq($sformatf("%s_rd%0d_addr", tag, i), 32'(rd_addr_q[rbase+i]), 32'(ea[i]));
            if (wbase + i < wr_addr_q.size()) begin
                check_eq($sformatf("%s_wr%0d_addr", tag, i), 32'(wr_addr_q[wbase+i]), 32'(ea[i]));
                check_eq($sformatf("%s_wr%0d_di", tag, i), 32'(wr_di_q[wbase+i]), 32'(ed[i]));
            end
        end
    endtask

    int rb, wb, t0, nden;

    initial begin
        // ---- reset values
        repeat (3) @(negedge sys_clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_mmcm_rst", 32'(mmcm_rst), 32'd1);
        check_eq("rst_den_dwe", 32'({drp_den, drp_dwe}), 32'd0);
        check_eq("rst_daddr_di", 32'({drp_daddr, drp_di}), 32'd0);
        check_eq("rst_rst_n_out", 32'(rst_n_out), 32'd0);

        // ---- power-up lock: locked first sampled at cycle 20
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        check_eq("mmcm_rst_after_release", 32'(mmcm_rst), 32'd0);
        repeat (18) @(negedge sys_clk);
        lock_manual = 1'b1;
        repeat (3) @(negedge sys_clk);
        check_eq("rst_n_out_cyc22", 32'(rst_n_out), 32'd0);
        @(negedge sys_clk);
        check_eq("rst_n_out_cyc23", 32'(rst_n_out), 32'd1);
        check_eq("powerup_busy", 32'(busy), 32'd0);
        check_eq("powerup_no_done", 32'(done_cnt), 32'd0);

        // ---- configuration 1, read data FFFF
        lock_mode = 1'b1;
        repeat (12) @(negedge sys_clk);
        rb = rd_addr_q.size();
        wb = wr_addr_q.size();
        request(1'b1);
        check_eq("cfg1_busy", 32'(busy), 32'd1);
        check_eq("cfg1_mmcm_rst", 32'(mmcm_rst), 32'd1);
        wait_cond(1, 300, "cfg1_complete");
        repeat (3) @(negedge sys_clk);
        check_run("cfg1", rb, wb, 16'h1145, 16'hFC80, 16'h1186, 16'hFCC0);
        check_eq("cfg1_rst_held", 32'(rst_viol), 32'd0);
        check_eq("cfg1_done_once", 32'(done_cnt), 32'd1);
        check_eq("cfg1_rst_n_out", 32'(rst_n_out), 32'd1);

        // ---- second read never answered -> DRP timeout
        rb = rd_addr_q.size();
        wb = wr_addr_q.size();
        withhold_at = rb + 2;
        request(1'b1);
        wait_cond(2, 300, "drp_to_err");
        // RD (1 cycle) then 64 RD_WAIT cycles before ERR
        check_eq("drp_to_len", 32'(cyc - den_cyc), 32'd65);
        check_eq("drp_to_mmcm_rst", 32'(mmcm_rst), 32'd1);
        check_eq("drp_to_busy", 32'(busy), 32'd0);
        check_eq("drp_to_nrd", 32'(rd_addr_q.size() - rb), 32'd2);
        check_eq("drp_to_nwr", 32'(wr_addr_q.size() - wb), 32'd1);

        // ---- recovery from ERR with configuration 0, read data A5A5
        withhold_at = -1;
        rd_value = 16'hA5A5;
        repeat (5) @(negedge sys_clk);
        rb = rd_addr_q.size();
        wb = wr_addr_q.size();
        request(1'b0);
        check_eq("recov_err_clear", 32'(err), 32'd0);
        wait_cond(1, 300, "recov_complete");
        repeat (3) @(negedge sys_clk);
        check_run("recov", rb, wb, 16'h0082, 16'hA440, 16'h0104, 16'hA400);
        check_eq("recov_done", 32'(done_cnt), 32'd2);

        // ---- no relock -> ERR after LOCK_TIMEOUT cycles in LOCK_WAIT
        rd_value = 16'hFFFF;
        lock_block = 1'b1;
        rb = rd_addr_q.size();
        wb = wr_addr_q.size();
        request(1'b0);
        wait_cond(3, 300, "lockto_release");
        t0 = cyc;
        wait_cond(2, LOCK_TO + 50, "lockto_err");
        check_eq("lockto_len", 32'(cyc - t0), 32'(LOCK_TO + 1));
        check_run("lockto", rb, wb, 16'h1082, 16'hFC40, 16'h1104, 16'hFC00);
        nden = rd_addr_q.size() + wr_addr_q.size();
        repeat (20) @(negedge sys_clk);
        check_eq("lockto_drp_idle", 32'(rd_addr_q.size() + wr_addr_q.size()), 32'(nden));
        check_eq("lockto_no_done", 32'(done_cnt), 32'd2);
        lock_block = 1'b0;
        request(1'b1);
        wait_cond(1, 300, "lockto_recover");

        // ---- lock lost for 10 cycles while idle
        repeat (3) @(negedge sys_clk);
        lock_manual = 1'b1;
        lock_mode   = 1'b0;
        repeat (5) @(negedge sys_clk);
        lock_manual = 1'b0;
        repeat (4) @(negedge sys_clk);
        check_eq("lockloss_rst_n_out", 32'(rst_n_out), 32'd0);
        check_eq("lockloss_busy", 32'(busy), 32'd0);
        repeat (6) @(negedge sys_clk);
        lock_manual = 1'b1;
        wait_cond(0, 20, "lockloss_relock");
        check_eq("lockloss_no_done", 32'(done_cnt), 32'd3);

        // ---- cfg_req during RD_WAIT is ignored
        lock_mode = 1'b1;
        repeat (3) @(negedge sys_clk);
        rb = rd_addr_q.size();
        wb = wr_addr_q.size();
        request(1'b1);
        wait_cond(4, 10, "ign_first_rd");
        @(negedge sys_clk);
        request(1'b0);
        wait_cond(1, 300, "ign_complete");
        repeat (3) @(negedge sys_clk);
        check_run("ign", rb, wb, 16'h1145, 16'hFC80, 16'h1186, 16'hFCC0);
        check_eq("ign_done", 32'(done_cnt), 32'd4);

        // ---- reset during a reconfiguration aborts DRP activity
        rb = rd_addr_q.size();
        wb = wr_addr_q.size();
        request(1'b0);
        wait_cond(4, 10, "abort_rd");
        sys_rst_n = 1'b0;
        #1;
        check_eq("abort_outputs", 32'({drp_den, mmcm_rst, busy, rst_n_out}), 32'b0100);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        wait_cond(0, 40, "abort_relock");
        repeat (10) @(negedge sys_clk);
        check_eq("abort_nrd", 32'(rd_addr_q.size() - rb), 32'd1);
        check_eq("abort_nwr", 32'(wr_addr_q.size() - wb), 32'd0);
        check_eq("abort_rst_held", 32'(rst_viol), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
